// File: rtl/conclover_engine.sv
// conclover_engine: correlation/convolution sequencer driving the conclover byte memory-access stage.
// y[i] = sat8((sum_k x[i+k]*c[k]) >>> shift), relative addressing only.
module conclover_engine #(
    parameter int TAPS  = 8,
    parameter int ACC_W = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] length,
    input  logic [3:0]  shift,
    input  logic        coef_we,
    input  logic [3:0]  coef_idx,
    input  logic [7:0]  coef_data,
    output logic        busy,
    output logic        done,
    output logic [15:0] mem_rel_addr,
    output logic        mem_read,
    output logic        mem_write,
    output logic [7:0]  mem_save_data,
    input  logic [7:0]  mem_read_data,
    input  logic        mem_rdy
);
    localparam int KW = (TAPS > 1) ? $clog2(TAPS) : 1;

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, MAC, WR_REQ, WR_WAIT, DONE} state_t;

    state_t                  state, state_nxt;
    logic signed [7:0]       coef [TAPS];
    logic [15:0]             len_q, i_q;
    logic [3:0]              shift_q;
    logic [KW-1:0]           k_q;
    logic [7:0]              x_q;
    logic signed [ACC_W-1:0] acc, acc_sh;
    logic signed [16:0]      x_ext, c_ext, prod;
    logic [7:0]              y_sat;
    logic                    last_tap, last_out;

    assign last_tap = k_q == KW'(TAPS - 1);
    assign last_out = i_q == len_q - 16'd1;
    assign x_ext    = {9'b0, x_q};
    assign c_ext    = {{9{coef[k_q][7]}}, coef[k_q]};
    assign prod     = x_ext * c_ext;
    assign acc_sh   = acc >>> shift_q;
    // negative clamps to 0, anything above the low byte clamps to 255
    assign y_sat    = acc_sh[ACC_W-1] ? 8'd0 : (|acc_sh[ACC_W-2:8]) ? 8'hff : acc_sh[7:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (length != 16'd0) ? RD_REQ : DONE;
            RD_REQ:  state_nxt = RD_WAIT;
            RD_WAIT: if (mem_rdy) state_nxt = MAC;
            MAC:     state_nxt = last_tap ? WR_REQ : RD_REQ;
            WR_REQ:  state_nxt = WR_WAIT;
            WR_WAIT: if (mem_rdy) state_nxt = last_out ? DONE : RD_REQ;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = state != IDLE && state != DONE;
        done = state == DONE;
    end

    // request strobes are registered so they appear for exactly the cycle after *_REQ
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < TAPS; j++) coef[j] <= '0;
            len_q         <= '0;
            shift_q       <= '0;
            i_q           <= '0;
            k_q           <= '0;
            x_q           <= '0;
            acc           <= '0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_rel_addr  <= '0;
            mem_save_data <= '0;
        end else begin
            mem_read  <= state == RD_REQ;
            mem_write <= state == WR_REQ;
            if (state == IDLE && coef_we && 32'(coef_idx) < TAPS)
                coef[coef_idx[KW-1:0]] <= coef_data;
            if (state == IDLE && start) begin
                len_q   <= length;
                shift_q <= shift;
                i_q     <= '0;
                k_q     <= '0;
                acc     <= '0;
            end
            if (state == RD_REQ)
                mem_rel_addr <= i_q + 16'(k_q);
            if (state == RD_WAIT && mem_rdy)
                x_q <= mem_read_data;
            if (state == MAC) begin
                acc <= acc + ACC_W'(prod);
                if (!last_tap) k_q <= k_q + 1'b1;
            end
            if (state == WR_REQ) begin
                mem_rel_addr  <= i_q;
                mem_save_data <= y_sat;
            end
            if (state == WR_WAIT && mem_rdy && !last_out) begin
                i_q <= i_q + 16'd1;
                k_q <= '0;
                acc <= '0;
            end
        end
    end
endmodule

// File: tb/tb_conclover_engine.sv
// tb_conclover_engine: random-latency access-stage model, protocol monitor and scoreboard of written outputs.
module tb_conclover_engine;
    logic        clk = 0, rst = 1, start = 0, coef_we = 0, mem_rdy = 0;
    logic [15:0] length = 0;
    logic [3:0]  shift = 0, coef_idx = 0;
    logic [7:0]  coef_data = 0, mem_read_data = 0;
    logic        busy, done, mem_read, mem_write;
    logic [15:0] mem_rel_addr;
    logic [7:0]  mem_save_data;

    always #5 clk = ~clk;

    conclover_engine dut (
        .clk(clk), .rst(rst), .start(start), .length(length), .shift(shift),
        .coef_we(coef_we), .coef_idx(coef_idx), .coef_data(coef_data),
        .busy(busy), .done(done), .mem_rel_addr(mem_rel_addr), .mem_read(mem_read),
        .mem_write(mem_write), .mem_save_data(mem_save_data),
        .mem_read_data(mem_read_data), .mem_rdy(mem_rdy)
    );

    int                checks = 0, errors = 0;
    logic [7:0]        xmem [0:65535];
    logic signed [7:0] cm [8];
    int                max_dly = 0;
    logic [23:0]       exp_q[$], obs_q[$];
    logic [15:0]       rd_q[$];
    int                n_done = 0, n_busy = 0, viol = 0;

    // access-stage model: one request at a time, rdy 1+max_dly cycles after the strobe
    logic        pend = 0, s_wr = 0;
    logic [15:0] s_addr = 0;
    int          cnt = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend    <= 1'b0;
            mem_rdy <= 1'b0;
            cnt     <= 0;
        end else begin
            mem_rdy       <= 1'b0;
            mem_read_data <= 8'($urandom);
            if (pend) begin
                if (cnt == 0) begin
                    mem_rdy <= 1'b1;
                    pend    <= 1'b0;
                    if (!s_wr) mem_read_data <= xmem[s_addr];
                end else
                    cnt <= cnt - 1;
            end else if (mem_read || mem_write) begin
                pend   <= 1'b1;
                s_wr   <= mem_write;
                s_addr <= mem_rel_addr;
                cnt    <= int'($urandom_range(max_dly, 0));
            end
        end
    end

    logic        pr = 0, pw = 0, outst = 0, hw = 0;
    logic [15:0] ha = 0;
    logic [7:0]  hd = 0;
    always @(negedge clk) begin
        if (rst) begin
            outst <= 1'b0;
            pr    <= 1'b0;
            pw    <= 1'b0;
        end else begin
            viol <= viol + int'(mem_read && mem_write) + int'((mem_read && pr) || (mem_write && pw))
                  + int'((mem_read || mem_write) && outst)
                  + int'(!(mem_read || mem_write) && outst && (mem_rel_addr !== ha || (hw && mem_save_data !== hd)));
            if (mem_read || mem_write) begin
                outst <= 1'b1;
                ha    <= mem_rel_addr;
                hd    <= mem_save_data;
                hw    <= mem_write;
            end else if (mem_rdy)
                outst <= 1'b0;
            if (mem_read) rd_q.push_back(mem_rel_addr);
            if (mem_write) obs_q.push_back({mem_rel_addr, mem_save_data});
            n_done <= n_done + int'(done);
            n_busy <= n_busy + int'(busy);
            pr <= mem_read;
            pw <= mem_write;
        end
    end

    function automatic int model_y(int i, int sh);
        int s = 0;
        for (int k = 0; k < 8; k++) s += int'(xmem[16'(i + k)]) * int'(cm[k]);
        s = s >>> sh;
        return s < 0 ? 0 : (s > 255 ? 255 : s);
    endfunction

    task automatic load_coefs();
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            coef_we   = 1;
            coef_idx  = 4'(j);
            coef_data = (j < 8) ? cm[j] : 8'($urandom_range(255, 1));
        end
        @(negedge clk);
        coef_we = 0;
    endtask

    task automatic kick(input int len, input int sh);
        exp_q.delete();
        obs_q.delete();
        rd_q.delete();
        for (int i = 0; i < len; i++) exp_q.push_back({16'(i), 8'(model_y(i, sh))});
        @(negedge clk);
        length = 16'(len);
        shift  = 4'(sh);
        start  = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int c = 0;
        while (done !== 1'b1 && c < budget) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: done not seen within %0d cycles", name, budget);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        checks++;
        if ({busy, done, mem_read, mem_write} !== 4'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got busy/done/rd/wr %b, expected 0000", {busy, done, mem_read, mem_write});
        end
        checks++;
        if (mem_rel_addr !== 16'd0) begin
            errors++;
            $display("FAIL reset_addr: got %0d, expected 0", mem_rel_addr);
        end
        checks++;
        if (mem_save_data !== 8'd0) begin
            errors++;
            $display("FAIL reset_data: got %0d, expected 0", mem_save_data);
        end
    endtask

    task automatic test_identity();
        logic [23:0] e, o;
        int d0;
        cm = '{default: 0};
        cm[0] = 1;
        xmem[0] = 10; xmem[1] = 20; xmem[2] = 30; xmem[3] = 40;
        load_coefs();
        d0 = n_done;
        kick(4, 0);
        wait_done("identity", 1000);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL identity_writes: got %0d writes, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL identity_y: got addr %0d data %0d, expected addr %0d data %0d", o[23:8], o[7:0], e[23:8], e[7:0]);
            end
        end
        checks++;
        if (rd_q.size() !== 32) begin
            errors++;
            $display("FAIL identity_reads: got %0d reads, expected 32", rd_q.size());
        end
        checks++;
        if (n_done - d0 !== 1) begin
            errors++;
            $display("FAIL identity_done: got %0d done cycles, expected 1", n_done - d0);
        end
    endtask

    task automatic test_box();
        logic [23:0] e, o;
        logic [15:0] a;
        cm = '{default: 1};
        for (int j = 0; j < 23; j++) xmem[j] = 8;
        load_coefs();
        kick(16, 3);
        wait_done("box", 4000);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL box_writes: got %0d writes, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL box_y: got addr %0d data %0d, expected addr %0d data %0d", o[23:8], o[7:0], e[23:8], e[7:0]);
            end
        end
        checks++;
        if (rd_q.size() !== 128) begin
            errors++;
            $display("FAIL box_reads: got %0d reads, expected 128", rd_q.size());
        end
        for (int i = 0; i < 16; i++)
            for (int k = 0; k < 8; k++)
                if (rd_q.size() > 0) begin
                    a = rd_q.pop_front();
                    checks++;
                    if (a !== 16'(i + k)) begin
                        errors++;
                        $display("FAIL box_addr: got %0d, expected %0d", a, i + k);
                    end
                end
    endtask

    task automatic test_saturation();
        logic [23:0] e, o;
        for (int r = 0; r < 3; r++) begin
            if (r == 0) cm = '{default: 8'sd127};
            if (r == 1) cm = '{default: 8'h80};
            if (r == 2) begin
                cm = '{default: 0};
                cm[0] = 3;
            end
            for (int j = 0; j < 10; j++) xmem[j] = (r == 2) ? 8'd100 : 8'd255;
            load_coefs();
            kick(2, (r == 2) ? 2 : 0);
            wait_done("sat", 600);
            checks++;
            if (obs_q.size() !== exp_q.size()) begin
                errors++;
                $display("FAIL sat_writes: case %0d got %0d writes, expected %0d", r, obs_q.size(), exp_q.size());
            end
            while (exp_q.size() > 0 && obs_q.size() > 0) begin
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL sat_y: case %0d got addr %0d data %0d, expected addr %0d data %0d", r, o[23:8], o[7:0], e[23:8], e[7:0]);
                end
            end
        end
    endtask

    task automatic test_zero_length();
        int d0, b0;
        d0 = n_done;
        b0 = n_busy;
        kick(0, 0);
        wait_done("zero_len", 4);
        checks++;
        if (obs_q.size() + rd_q.size() !== 0) begin
            errors++;
            $display("FAIL zero_len_traffic: got %0d requests, expected 0", obs_q.size() + rd_q.size());
        end
        checks++;
        if (n_done - d0 !== 1) begin
            errors++;
            $display("FAIL zero_len_done: got %0d done cycles, expected 1", n_done - d0);
        end
        checks++;
        if (n_busy - b0 !== 0) begin
            errors++;
            $display("FAIL zero_len_busy: got %0d busy cycles, expected 0", n_busy - b0);
        end
    endtask

    task automatic test_busy_start();
        logic [23:0] e, o;
        int d0;
        cm = '{default: 0};
        cm[0] = 1;
        load_coefs();
        d0 = n_done;
        kick(3, 0);
        repeat (4) @(negedge clk);
        start     = 1;
        length    = 7;
        coef_we   = 1;
        coef_idx  = 0;
        coef_data = 8'd9;
        @(negedge clk);
        start   = 0;
        coef_we = 0;
        wait_done("busy_start", 1000);
        repeat (20) @(negedge clk);
        checks++;
        if (obs_q.size() !== 3) begin
            errors++;
            $display("FAIL busy_start_writes: got %0d writes, expected 3", obs_q.size());
        end
        checks++;
        if (n_done - d0 !== 1) begin
            errors++;
            $display("FAIL busy_start_done: got %0d done cycles, expected 1", n_done - d0);
        end
        kick(2, 0);
        wait_done("busy_coef", 600);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL busy_coef_y: got addr %0d data %0d, expected addr %0d data %0d", o[23:8], o[7:0], e[23:8], e[7:0]);
            end
        end
    endtask

    task automatic test_handshake();
        logic [23:0] e, o;
        for (int j = 0; j < 8; j++) cm[j] = 8'($urandom);
        for (int j = 0; j < 16; j++) xmem[j] = 8'($urandom);
        load_coefs();
        max_dly = 20;
        kick(6, 5);
        wait_done("handshake", 3000);
        max_dly = 0;
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL handshake_writes: got %0d writes, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL handshake_y: got addr %0d data %0d, expected addr %0d data %0d", o[23:8], o[7:0], e[23:8], e[7:0]);
            end
        end
        checks++;
        if (viol !== 0) begin
            errors++;
            $display("FAIL handshake_protocol: got %0d violations, expected 0", viol);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [23:0] e, o;
        int seen = 0, c = 0, nz = 0;
        for (int j = 0; j < 8; j++) cm[j] = 8'($urandom);
        load_coefs();
        max_dly = 5;
        kick(4, 0);
        while (seen < 3 && c < 500) begin
            @(negedge clk);
            c++;
            if (mem_read) seen++;
        end
        checks++;
        if (seen < 3) begin
            errors++;
            $display("FAIL midrst_wait: got %0d reads, expected 3", seen);
        end
        rst = 1;
        @(negedge clk);
        checks++;
        if ({busy, done, mem_read, mem_write} !== 4'b0 || mem_rel_addr !== 16'd0 || mem_save_data !== 8'd0) begin
            errors++;
            $display("FAIL midrst_outputs: got ctrl %b addr %0d data %0d, expected all 0", {busy, done, mem_read, mem_write}, mem_rel_addr, mem_save_data);
        end
        for (int j = 0; j < 8; j++) if (dut.coef[j] !== 8'sd0) nz++;
        checks++;
        if (nz !== 0) begin
            errors++;
            $display("FAIL midrst_coef: got %0d nonzero coefficients, expected 0", nz);
        end
        rst = 0;
        max_dly = 0;
        @(negedge clk);
        for (int j = 0; j < 8; j++) cm[j] = 8'($urandom_range(20, 0));
        load_coefs();
        kick(4, 1);
        wait_done("midrst_rerun", 1000);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL midrst_writes: got %0d writes, expected %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL midrst_y: got addr %0d data %0d, expected addr %0d data %0d", o[23:8], o[7:0], e[23:8], e[7:0]);
            end
        end
    endtask

    initial begin
        for (int j = 0; j < 65536; j++) xmem[j] = 8'($urandom);
        test_reset();
        test_identity();
        test_box();
        test_saturation();
        test_zero_length();
        test_busy_start();
        test_handshake();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
